// File: rtl/w0rm_alu_arith_ext.sv
// w0rm_alu_arith_ext: arithmetic execution slice of the W0RM core ALU.
// Performs add/subtract, sign/zero extend and (optionally) an iterative
// unsigned divide/remainder, returning a result, a valid strobe and flags.
//
// Optional feature macro: W0RM_ALU_DIVREM_EN
//   defined   -> restoring divider FSM (IDLE -> RUN -> DONE), DIV/REM supported
//   undefined -> no divider; DIV/REM behave like unsupported opcodes
//
// Parameters:
//   SINGLE_CYCLE  1: ADD/SUB/SEX/ZEX combinational, 0: one-cycle registered
//   DATA_WIDTH    operand/result width (>= 8)
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   data_valid    operation request
//   opcode        6 DIV, 7 REM, 8 ADD, 9 SUB, A SEX, B ZEX
//   ext_8_16      extend source size (1 = 16-bit, 0 = 8-bit)
//   data_a        operand A (dividend, minuend, extend source)
//   data_b        operand B (divisor, subtrahend)
//   result        operation result
//   result_valid  result/flags valid strobe
//   result_flags  {carry, overflow, negative, zero}
module w0rm_alu_arith_ext #(
    parameter bit          SINGLE_CYCLE = 1'b0,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_valid,
    input  logic [3:0]            opcode,
    input  logic                  ext_8_16,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic [3:0]            result_flags
);

    localparam int unsigned MSB       = DATA_WIDTH - 1;
    // Sign bit of a 16-bit source; when 16 >= DATA_WIDTH the extend is a passthrough anyway.
    localparam int unsigned SRC16_MSB = (DATA_WIDTH > 16) ? 15 : DATA_WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'h8;
    localparam logic [3:0] OP_SUB = 4'h9;
    localparam logic [3:0] OP_SEX = 4'hA;
    localparam logic [3:0] OP_ZEX = 4'hB;

    logic [DATA_WIDTH:0]   add_full;
    logic [DATA_WIDTH:0]   sub_full;
    logic [DATA_WIDTH-1:0] ext_val;
    logic                  ext_sign;
    int unsigned           ext_src;
    logic [DATA_WIDTH-1:0] comb_result;
    logic                  comb_carry;
    logic                  comb_ovf;
    logic [3:0]            comb_flags;

    logic                  div_is_op;
    logic                  div_idle;
    logic                  div_fire;
    logic [DATA_WIDTH-1:0] div_res;
    logic                  div_ovf;
    logic                  accept_c;

    logic [DATA_WIDTH-1:0] q_result;
    logic [3:0]            q_flags;
    logic                  q_valid;

    // Single-cycle datapath for ADD/SUB/SEX/ZEX and unsupported opcodes.
    always_comb begin
        add_full    = {1'b0, data_a} + {1'b0, data_b};
        sub_full    = {1'b0, data_a} - {1'b0, data_b};
        ext_src     = ext_8_16 ? 32'd16 : 32'd8;
        ext_sign    = ext_8_16 ? data_a[SRC16_MSB] : data_a[7];
        ext_val     = '0;
        comb_result = '0;
        comb_carry  = 1'b0;
        comb_ovf    = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            ext_val[i] = (i < ext_src) ? data_a[i] : ((opcode == OP_SEX) & ext_sign);
        end
        case (opcode)
            OP_ADD: begin
                comb_result = add_full[MSB:0];
                comb_carry  = add_full[DATA_WIDTH];
                comb_ovf    = (data_a[MSB] == data_b[MSB]) && (add_full[MSB] != data_a[MSB]);
            end
            OP_SUB: begin
                comb_result = sub_full[MSB:0];
                comb_carry  = ~sub_full[DATA_WIDTH];
                comb_ovf    = (data_a[MSB] != data_b[MSB]) && (sub_full[MSB] != data_a[MSB]);
            end
            OP_SEX, OP_ZEX: comb_result = ext_val;
            default: comb_result = '0;
        endcase
        comb_flags = {comb_carry, comb_ovf, comb_result[MSB], (comb_result == '0)};
    end

`ifdef W0RM_ALU_DIVREM_EN
    localparam logic [3:0]        OP_DIV   = 4'h6;
    localparam logic [3:0]        OP_REM   = 4'h7;
    localparam int unsigned       CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    div_state_t            div_state;
    logic [DATA_WIDTH-1:0] div_rem;
    logic [DATA_WIDTH-1:0] div_quo;
    logic [DATA_WIDTH-1:0] div_b;
    logic                  div_is_rem;
    logic [CNT_W-1:0]      div_cnt;
    logic [DATA_WIDTH:0]   div_trial;
    logic                  div_fits;

    // Restoring step: shift the next dividend bit into the partial remainder.
    // A zero divisor always "fits", giving all-ones quotient and remainder = a.
    always_comb begin
        div_trial = {div_rem, div_quo[MSB]};
        div_fits  = (div_trial >= {1'b0, div_b});
    end

    assign div_is_op = (opcode == OP_DIV) || (opcode == OP_REM);
    assign div_idle  = (div_state == DIV_IDLE);
    assign div_fire  = (div_state == DIV_DONE);
    assign div_res   = div_is_rem ? div_rem : div_quo;
    assign div_ovf   = (div_b == '0);

    // Divider FSM; the quotient register starts as the dividend and shifts out.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_state  <= DIV_IDLE;
            div_rem    <= '0;
            div_quo    <= '0;
            div_b      <= '0;
            div_is_rem <= 1'b0;
            div_cnt    <= '0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (data_valid && div_is_op) begin
                        div_rem    <= '0;
                        div_quo    <= data_a;
                        div_b      <= data_b;
                        div_is_rem <= (opcode == OP_REM);
                        div_cnt    <= '0;
                        div_state  <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    div_rem <= div_fits ? DATA_WIDTH'(div_trial - {1'b0, div_b}) : div_trial[MSB:0];
                    div_quo <= {div_quo[MSB-1:0], div_fits};
                    div_cnt <= div_cnt + CNT_W'(1);
                    if (div_cnt == DIV_LAST) begin
                        div_state <= DIV_DONE;
                    end
                end
                DIV_DONE: div_state <= DIV_IDLE;
                default:  div_state <= DIV_IDLE;
            endcase
        end
    end
`else
    assign div_is_op = 1'b0;
    assign div_idle  = 1'b1;
    assign div_fire  = 1'b0;
    assign div_res   = '0;
    assign div_ovf   = 1'b0;
`endif

    // Non-divide request accepted only while the divider is idle.
    assign accept_c = data_valid && div_idle && !div_is_op;

    // Output registers: divider completion, or the registered-mode datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_result <= '0;
            q_flags  <= '0;
            q_valid  <= 1'b0;
        end else begin
            q_valid <= 1'b0;
            if (div_fire) begin
                q_result <= div_res;
                q_flags  <= {1'b0, div_ovf, div_res[MSB], (div_res == '0)};
                q_valid  <= 1'b1;
            end else if (!SINGLE_CYCLE && accept_c) begin
                q_result <= comb_result;
                q_flags  <= comb_flags;
                q_valid  <= 1'b1;
            end
        end
    end

    // In single-cycle mode a divider completion takes priority over a same-cycle op.
    if (SINGLE_CYCLE) begin : g_comb_out
        assign result       = q_valid ? q_result : comb_result;
        assign result_flags = q_valid ? q_flags : comb_flags;
        assign result_valid = q_valid | accept_c;
    end else begin : g_reg_out
        assign result       = q_result;
        assign result_flags = q_flags;
        assign result_valid = q_valid;
    end

endmodule

// File: tb/tb_w0rm_alu_arith_ext.sv
// Scoreboard bench: dut8 (registered, 8-bit) and dut16 (single-cycle, 16-bit).
module tb_w0rm_alu_arith_ext;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       dv8;
    logic [3:0] op8;
    logic       ext8;
    logic [7:0] a8, b8, r8;
    logic       v8;
    logic [3:0] f8;

    logic        dv16;
    logic [3:0]  op16;
    logic        ext16;
    logic [15:0] a16, b16, r16;
    logic        v16;
    logic [3:0]  f16;

    w0rm_alu_arith_ext #(.SINGLE_CYCLE(1'b0), .DATA_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .data_valid(dv8), .opcode(op8), .ext_8_16(ext8),
        .data_a(a8), .data_b(b8), .result(r8), .result_valid(v8), .result_flags(f8)
    );

    w0rm_alu_arith_ext #(.SINGLE_CYCLE(1'b1), .DATA_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .data_valid(dv16), .opcode(op16), .ext_8_16(ext16),
        .data_a(a16), .data_b(b16), .result(r16), .result_valid(v16), .result_flags(f16)
    );

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [3:0]  flg;
        int          due;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } dchk_t;

    exp_t  sb8[$];
    exp_t  sb16[$];
    dchk_t dq[$];

    int n_total  = 0;
    int n_pass   = 0;
    int n_valid8 = 0;

    localparam logic [3:0] OP_DIV = 4'h6;
    localparam logic [3:0] OP_REM = 4'h7;
    localparam logic [3:0] OP_ADD = 4'h8;
    localparam logic [3:0] OP_SUB = 4'h9;
    localparam logic [3:0] OP_SEX = 4'hA;
    localparam logic [3:0] OP_ZEX = 4'hB;

    // Monitor: pops expectations on every result_valid and drains direct checks.
    initial begin : monitor
        exp_t  e;
        dchk_t d;
        forever begin
            @(negedge clk);
            if (v8) begin
                n_valid8++;
                n_total++;
                if (sb8.size() == 0) begin
                    $display("FAIL dut8_unexpected_valid: cycle %0d result=%h flags=%b, no result expected", cyc, r8, f8);
                end else begin
                    e = sb8.pop_front();
                    if (r8 == e.res[7:0] && f8 == e.flg && cyc == e.due) n_pass++;
                    else $display("FAIL %s: got result=%h flags=%b cycle=%0d, want result=%h flags=%b cycle=%0d",
                                  e.name, r8, f8, cyc, e.res[7:0], e.flg, e.due);
                end
            end
            if (v16) begin
                n_total++;
                if (sb16.size() == 0) begin
                    $display("FAIL dut16_unexpected_valid: cycle %0d result=%h flags=%b, no result expected", cyc, r16, f16);
                end else begin
                    e = sb16.pop_front();
                    if (r16 == e.res && f16 == e.flg && cyc == e.due) n_pass++;
                    else $display("FAIL %s: got result=%h flags=%b cycle=%0d, want result=%h flags=%b cycle=%0d",
                                  e.name, r16, f16, cyc, e.res, e.flg, e.due);
                end
            end
            while (dq.size() > 0) begin
                d = dq.pop_front();
                n_total++;
                if (d.act == d.exp) n_pass++;
                else $display("FAIL %s: got %0d, want %0d", d.name, d.act, d.exp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic direct(input string name, input int act, input int exp);
        dchk_t d;
        d.name = name;
        d.act  = act;
        d.exp  = exp;
        dq.push_back(d);
    endtask

    task automatic drive8(input logic [3:0] op, input logic ext, input logic [7:0] a, input logic [7:0] b,
                          input string name, input logic [7:0] res, input logic [3:0] flg, input int lat);
        exp_t e;
        dv8 = 1'b1; op8 = op; ext8 = ext; a8 = a; b8 = b;
        e.name = name; e.res = {8'h00, res}; e.flg = flg; e.due = cyc + lat;
        sb8.push_back(e);
    endtask

    task automatic drive16(input logic [3:0] op, input logic ext, input logic [15:0] a, input logic [15:0] b,
                           input string name, input logic [15:0] res, input logic [3:0] flg);
        exp_t e;
        dv16 = 1'b1; op16 = op; ext16 = ext; a16 = a; b16 = b;
        e.name = name; e.res = res; e.flg = flg; e.due = cyc;
        sb16.push_back(e);
    endtask

    initial begin : driver
        int base;
        reset = 1'b1;
        dv8 = 1'b0; op8 = 4'h0; ext8 = 1'b0; a8 = '0; b8 = '0;
        dv16 = 1'b0; op16 = 4'h0; ext16 = 1'b0; a16 = '0; b16 = '0;
        step(3);
        @(negedge clk);
        direct("reset_result8", int'(r8), 0);
        direct("reset_valid8", int'(v8), 0);
        direct("reset_flags8", int'(f8), 0);
        direct("reset_valid16", int'(v16), 0);
        step(1);
        reset = 1'b0;

        // Registered 8-bit slice, back-to-back requests
        step(1); drive8(OP_ADD, 1'b0, 8'h7F, 8'h01, "add_7f_01", 8'h80, 4'b0110, 1);
        step(1); drive8(OP_ADD, 1'b0, 8'hFF, 8'h01, "add_ff_01", 8'h00, 4'b1001, 1);
        step(1); drive8(OP_SUB, 1'b0, 8'h05, 8'h07, "sub_05_07", 8'hFE, 4'b0010, 1);
        step(1); drive8(OP_SUB, 1'b0, 8'h10, 8'h10, "sub_10_10", 8'h00, 4'b1001, 1);
        step(1); drive8(OP_SUB, 1'b0, 8'h80, 8'h01, "sub_80_01", 8'h7F, 4'b1100, 1);
        step(1); drive8(OP_SEX, 1'b0, 8'h80, 8'h00, "sex8_w8", 8'h80, 4'b0010, 1);
        step(1); drive8(OP_ZEX, 1'b1, 8'hF0, 8'h55, "zex16_w8", 8'hF0, 4'b0010, 1);
        step(1); drive8(4'hF, 1'b0, 8'h12, 8'h34, "unsup_f", 8'h00, 4'b0001, 1);
        step(1); drive8(OP_ADD, 1'b0, 8'h7F, 8'h01, "add_hold", 8'h80, 4'b0110, 1);
        step(1); dv8 = 1'b0;
        step(2);
        @(negedge clk);
        direct("hold_result8", int'(r8), 8'h80);
        direct("hold_flags8", int'(f8), 4'b0110);
        direct("hold_valid8", int'(v8), 0);

`ifdef W0RM_ALU_DIVREM_EN
        // DIV held high, then switched to REM the cycle after completion
        step(1); drive8(OP_DIV, 1'b0, 8'd200, 8'd7, "div_200_7", 8'd28, 4'b0000, 10);
        step(10); drive8(OP_REM, 1'b0, 8'd200, 8'd7, "rem_200_7", 8'd4, 4'b0000, 10);
        step(10); dv8 = 1'b0;
        step(1); drive8(OP_DIV, 1'b0, 8'd5, 8'd0, "div_5_0", 8'hFF, 4'b0110, 10);
        step(1); dv8 = 1'b0;
        step(12);
        step(1); drive8(OP_REM, 1'b0, 8'd9, 8'd0, "rem_9_0", 8'd9, 4'b0100, 10);
        step(1); dv8 = 1'b0;
        step(12);

        // Reset in the middle of RUN must abort without a result
        dv8 = 1'b1; op8 = OP_DIV; a8 = 8'd100; b8 = 8'd3;
        step(1); dv8 = 1'b0;
        step(3); reset = 1'b1;
        step(1); reset = 1'b0;
        base = n_valid8;
        step(15);
        @(negedge clk);
        direct("rst_abort_valids", n_valid8 - base, 0);
        direct("rst_abort_result8", int'(r8), 0);
        step(1); drive8(OP_DIV, 1'b0, 8'd100, 8'd3, "div_after_rst", 8'd33, 4'b0000, 10);
        step(1); dv8 = 1'b0;
        step(12);
`else
        step(1); drive8(OP_DIV, 1'b0, 8'd200, 8'd7, "div_disabled", 8'h00, 4'b0001, 1);
        step(1); drive8(OP_REM, 1'b0, 8'd200, 8'd7, "rem_disabled", 8'h00, 4'b0001, 1);
        step(1); dv8 = 1'b0;
        step(3);
        base = n_valid8;
`endif

        // Single-cycle 16-bit slice
        step(1); drive16(OP_SEX, 1'b0, 16'h0080, 16'h0000, "sex8_w16", 16'hFF80, 4'b0010);
        step(1); drive16(OP_ZEX, 1'b0, 16'h0080, 16'h0000, "zex8_w16", 16'h0080, 4'b0000);
        step(1); drive16(OP_SEX, 1'b1, 16'h8234, 16'h0000, "sex16_w16", 16'h8234, 4'b0010);
        step(1); drive16(OP_SEX, 1'b0, 16'h1234, 16'h0000, "sex8_pos_w16", 16'h0034, 4'b0000);
        step(1); drive16(OP_ADD, 1'b0, 16'hFFFF, 16'h0001, "add16_wrap", 16'h0000, 4'b1001);
        step(1); drive16(OP_SUB, 1'b0, 16'h8000, 16'h0001, "sub16_ovf", 16'h7FFF, 4'b1100);
        step(1); drive16(4'h0, 1'b0, 16'h1234, 16'h5678, "unsup16", 16'h0000, 4'b0001);
        step(1); dv16 = 1'b0;
        step(3);

        @(negedge clk);
        direct("sb8_drained", sb8.size(), 0);
        direct("sb16_drained", sb16.size(), 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
